// File: rtl/fetch_queue_ifid_if.sv
// Fetch-to-decode bundle: PC/imem inputs and stall/flush control, IF/ID word and queue status back.
interface fetch_queue_ifid_if #(parameter int DW = 16);
  logic [DW-1:0] pc_in;
  logic          fetch_req;
  logic [DW-1:0] imem_rdata;
  logic          stall;
  logic          flush;
  logic [DW-1:0] if_instr;
  logic [DW-1:0] if_pc;
  logic          if_valid;
  logic          hlt_out;
  logic          fq_hold;
  logic [1:0]    fq_count;

  modport master (
    output pc_in, fetch_req, imem_rdata, stall, flush,
    input  if_instr, if_pc, if_valid, hlt_out, fq_hold, fq_count
  );

  modport slave (
    input  pc_in, fetch_req, imem_rdata, stall, flush,
    output if_instr, if_pc, if_valid, hlt_out, fq_hold, fq_count
  );
endinterface

// File: rtl/fetch_queue_ifid.sv
// IF/ID fetch queue: 2-entry bypass FIFO on sync imem data, fetch_req->if_instr in 2 edges; fq_hold stalls PC when full.
// Optional IFQ_PERF_EN adds saturating stall/flush cycle counters.
module fetch_queue_ifid #(
  parameter int              DW         = 16,
  parameter logic [DW-1:0]   NOP_INSTR  = '0,
  parameter logic [3:0]      HLT_OPCODE = 4'hF
) (
  input  logic               clk,
  input  logic               rst_n,
  fetch_queue_ifid_if.slave  bus
`ifdef IFQ_PERF_EN
  ,
  output logic [15:0]        perf_stall_cnt,
  output logic [15:0]        perf_flush_cnt
`endif
);

  typedef struct packed {
    logic [DW-1:0] pc;
    logic [DW-1:0] instr;
  } entry_t;

  typedef enum logic {RUN, HALT} state_t;

  state_t        state;
  logic          rd_vld;
  logic [DW-1:0] rd_pc;
  entry_t        q [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    count;
  logic [DW-1:0] if_instr;
  logic [DW-1:0] if_pc;
  logic          if_valid;
  logic          hlt_out;

  entry_t rd_word;
  entry_t load_word;
  logic   run_adv;
  logic   deq;
  logic   bypass;
  logic   enq;
  logic   load_vld;

  always_comb begin
    rd_word   = '{pc: rd_pc, instr: bus.imem_rdata};
    run_adv   = ~bus.stall & (state == RUN);
    deq       = run_adv & (count != 2'd0);
    bypass    = run_adv & (count == 2'd0) & rd_vld;
    // A word arriving while full only fits if the head leaves on the same edge.
    enq       = rd_vld & ~bypass & ((count != 2'd2) | deq);
    load_vld  = deq | bypass;
    load_word = deq ? q[rd_ptr] : rd_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      rd_vld   <= 1'b0;
      rd_pc    <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
      if_instr <= NOP_INSTR;
      if_pc    <= '0;
      if_valid <= 1'b0;
      hlt_out  <= 1'b0;
      for (int i = 0; i < 2; i++) q[i] <= '0;
    end else begin
      rd_pc <= bus.pc_in;
      if (bus.flush) begin
        state    <= RUN;
        rd_vld   <= 1'b0;
        wr_ptr   <= 1'b0;
        rd_ptr   <= 1'b0;
        count    <= 2'd0;
        if_instr <= NOP_INSTR;
        if_valid <= 1'b0;
        hlt_out  <= 1'b0;
      end else begin
        rd_vld <= bus.fetch_req & ~hlt_out;
        if (enq) begin
          q[wr_ptr] <= rd_word;
          wr_ptr    <= ~wr_ptr;
        end
        if (deq) rd_ptr <= ~rd_ptr;
        case ({enq, deq})
          2'b10:   count <= count + 2'd1;
          2'b01:   count <= count - 2'd1;
          default: count <= count;
        endcase
        // Stall and HALT both leave IF/ID untouched.
        if (run_adv) begin
          if (load_vld) begin
            if_instr <= load_word.instr;
            if_pc    <= load_word.pc;
            if_valid <= 1'b1;
            if (load_word.instr[DW-1 -: 4] == HLT_OPCODE) begin
              state   <= HALT;
              hlt_out <= 1'b1;
            end
          end else begin
            if_instr <= NOP_INSTR;
            if_valid <= 1'b0;
          end
        end
      end
    end
  end

`ifdef IFQ_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= 16'd0;
      perf_flush_cnt <= 16'd0;
    end else begin
      if (bus.stall && perf_stall_cnt != 16'hFFFF) perf_stall_cnt <= perf_stall_cnt + 16'd1;
      if (bus.flush && perf_flush_cnt != 16'hFFFF) perf_flush_cnt <= perf_flush_cnt + 16'd1;
    end
  end
`endif

  assign bus.if_instr = if_instr;
  assign bus.if_pc    = if_pc;
  assign bus.if_valid = if_valid;
  assign bus.hlt_out  = hlt_out;
  assign bus.fq_count = count;
  assign bus.fq_hold  = (count == 2'd2) | ((count == 2'd1) & (bus.stall | hlt_out));

endmodule

// File: tb/tb_fetch_queue_ifid.sv
// Directed bench for fetch_queue_ifid: in-order fetch, stall absorb, flush, HLT entry/exit.
module tb_fetch_queue_ifid;
  logic clk;
  logic rst_n;
  int   n_total;
  int   n_pass;

  fetch_queue_ifid_if #(.DW(16)) bus ();

`ifdef IFQ_PERF_EN
  logic [15:0] perf_stall_cnt;
  logic [15:0] perf_flush_cnt;
  int          exp_stall;
  int          exp_flush;
`endif

  fetch_queue_ifid dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus)
`ifdef IFQ_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] imem_word(input logic [15:0] pc);
    return (pc == 16'd7) ? 16'hF000 : (16'hA000 + pc);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    else
      n_pass++;
  endtask

  // Sync-read imem: data for the address presented this cycle shows up after the edge.
  task automatic tick();
    logic [15:0] last;
    last = bus.pc_in;
    @(posedge clk);
    #1;
    bus.imem_rdata = imem_word(last);
  endtask

  task automatic cyc(input int pc, input bit req, input bit st, input bit fl);
    bus.pc_in     = pc[15:0];
    bus.fetch_req = req;
    bus.stall     = st;
    bus.flush     = fl;
`ifdef IFQ_PERF_EN
    if (st) exp_stall++;
    if (fl) exp_flush++;
`endif
    tick();
  endtask

  task automatic chk_ifid(input string tag, input logic [15:0] instr, input logic [15:0] pc);
    chk({tag, "_instr"}, 32'(bus.if_instr), 32'(instr));
    chk({tag, "_pc"},    32'(bus.if_pc),    32'(pc));
    chk({tag, "_valid"}, 32'(bus.if_valid), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_total = 0;
    n_pass  = 0;
`ifdef IFQ_PERF_EN
    exp_stall = 0;
    exp_flush = 0;
`endif
    rst_n          = 1'b0;
    bus.pc_in      = '0;
    bus.fetch_req  = 1'b0;
    bus.imem_rdata = '0;
    bus.stall      = 1'b0;
    bus.flush      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_instr", 32'(bus.if_instr), 32'h0000);
    chk("rst_pc",    32'(bus.if_pc),    32'h0000);
    chk("rst_valid", 32'(bus.if_valid), 32'd0);
    chk("rst_hlt",   32'(bus.hlt_out),  32'd0);
    chk("rst_count", 32'(bus.fq_count), 32'd0);
    chk("rst_hold",  32'(bus.fq_hold),  32'd0);
    rst_n = 1'b1;

    // In-order fetch with bypass, two-edge latency
    cyc(0, 1, 0, 0);
    chk("t1_bubble", 32'(bus.if_valid), 32'd0);
    for (int i = 1; i <= 5; i++) begin
      cyc(i, 1, 0, 0);
      chk_ifid("t1", 16'hA000 + 16'(i - 1), 16'(i - 1));
      chk("t1_count", 32'(bus.fq_count), 32'd0);
    end

    // Stall absorbs in-flight A005
    for (int i = 0; i < 3; i++) begin
      cyc(6, 0, 1, 0);
      chk_ifid("t2_hold", 16'hA004, 16'd4);
      chk("t2_count", 32'(bus.fq_count), 32'd1);
      chk("t2_hold_out", 32'(bus.fq_hold), 32'd1);
    end
    cyc(6, 1, 0, 0);
    chk_ifid("t2_rel", 16'hA005, 16'd5);
    chk("t2_rel_count", 32'(bus.fq_count), 32'd0);
    cyc(20, 0, 0, 0);
    chk_ifid("t2_next", 16'hA006, 16'd6);

    // Fill queue to 2 under stall, then flush+stall together
    cyc(10, 1, 0, 0);
    chk("t3_bubble", 32'(bus.if_valid), 32'd0);
    cyc(11, 1, 1, 0);
    chk("t3_count1", 32'(bus.fq_count), 32'd1);
    cyc(12, 1, 1, 0);
    chk("t3_count2", 32'(bus.fq_count), 32'd2);
    chk("t3_full_hold", 32'(bus.fq_hold), 32'd1);
    cyc(13, 1, 1, 1);
    chk("t3_fl_valid", 32'(bus.if_valid), 32'd0);
    chk("t3_fl_instr", 32'(bus.if_instr), 32'h0000);
    chk("t3_fl_count", 32'(bus.fq_count), 32'd0);
    cyc(30, 1, 0, 0);
    chk("t3_fl_bubble", 32'(bus.if_valid), 32'd0);
    cyc(31, 0, 0, 0);
    chk_ifid("t3_resume", 16'hA01E, 16'd30);

    // HLT at pc 7 reached from the queue head
    cyc(7, 1, 0, 0);
    chk("t4_pre_hlt", 32'(bus.hlt_out), 32'd0);
    cyc(8, 1, 1, 0);
    chk("t4_q1", 32'(bus.fq_count), 32'd1);
    cyc(9, 1, 0, 0);
    chk_ifid("t4_hlt", 16'hF000, 16'd7);
    chk("t4_hlt_out", 32'(bus.hlt_out), 32'd1);
    chk("t4_count1", 32'(bus.fq_count), 32'd1);
    chk("t4_hold1", 32'(bus.fq_hold), 32'd1);
    cyc(10, 1, 0, 0);
    chk_ifid("t4_keep", 16'hF000, 16'd7);
    chk("t4_count2", 32'(bus.fq_count), 32'd2);
    chk("t4_hold2", 32'(bus.fq_hold), 32'd1);
    cyc(10, 1, 0, 0);
    chk_ifid("t4_keep2", 16'hF000, 16'd7);
    chk("t4_sticky", 32'(bus.hlt_out), 32'd1);
    chk("t4_count_sat", 32'(bus.fq_count), 32'd2);

    // Flush out of HALT and refetch from redirect target
    cyc(40, 1, 0, 1);
    chk("t5_hlt", 32'(bus.hlt_out), 32'd0);
    chk("t5_count", 32'(bus.fq_count), 32'd0);
    chk("t5_valid", 32'(bus.if_valid), 32'd0);
    cyc(40, 1, 0, 0);
    chk("t5_bubble", 32'(bus.if_valid), 32'd0);
    cyc(41, 1, 0, 0);
    chk_ifid("t5_r0", 16'hA028, 16'd40);
    cyc(42, 0, 0, 0);
    chk_ifid("t5_r1", 16'hA029, 16'd41);
    chk("t5_run", 32'(bus.hlt_out), 32'd0);

`ifdef IFQ_PERF_EN
    chk("perf_stall", 32'(perf_stall_cnt), 32'(exp_stall));
    chk("perf_flush", 32'(perf_flush_cnt), 32'(exp_flush));
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
